// File: rtl/step_cmd_reader_pkg.sv
// step_cmd_pkg: shared types and command-word field helpers for step_cmd_reader.
// Command word layout: [CMD_W-1] = dir, [CMD_W-2:0] = step period in clk cycles.
package step_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SETUP = 3'd3,
    STEP  = 3'd4
  } state_t;

  localparam int unsigned CMD_W    = 16;
  localparam int unsigned DIR_BIT  = CMD_W - 1;
  localparam int unsigned PERIOD_W = CMD_W - 1;

  function automatic logic cmd_dir(input logic [CMD_W-1:0] w);
    return w[DIR_BIT];
  endfunction

  function automatic logic [PERIOD_W-1:0] cmd_period(input logic [CMD_W-1:0] w);
    return w[PERIOD_W-1:0];
  endfunction

  // Short periods (including 0) are raised silently to the minimum.
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p,
                                                       input int unsigned         min_p);
    if (32'(p) < min_p) return PERIOD_W'(min_p);
    return p;
  endfunction

endpackage

// File: rtl/step_cmd_reader_timer.sv
// step_pulse_timer: per-step cycle counter. cnt is 0 on the step-rise cycle.
// pulse is the registered STEP output (high for cnt 0..PULSE_W-1).
// pre_pt marks cnt==P-3 so a registered pop lands on cnt==P-2;
// done marks cnt==P-1, the last cycle of the period.
module step_pulse_timer
  import step_cmd_pkg::*;
#(
  parameter int unsigned PULSE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                pulse,
  output logic                pre_pt,
  output logic                done
);

  logic [PERIOD_W-1:0] cnt;
  logic [31:0]         cnt_nxt;

  assign cnt_nxt = 32'(cnt) + 32'd1;
  assign pre_pt  = run && ((cnt_nxt + 32'd2) == 32'(period));
  assign done    = run && (cnt_nxt == 32'(period));

  // Count through the period; saturate rather than wrap, restart on each step rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      pulse <= 1'b1;
    end else if (run) begin
      if (cnt != '1) cnt <= cnt + PERIOD_W'(1);
      pulse <= (cnt_nxt < PULSE_W);
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/step_cmd_reader.sv
// step_cmd_reader: read side of the 16-bit command FIFO; turns command words
// into STEP/DIR with fixed pulse width, DIR setup time and exact spacing.
// Optional STEP_POS_EN: adds a signed position counter on the position port.
//
//   state | meaning
//   IDLE  | stopped, waiting for enable && !fifo_empty
//   FETCH | pop strobe high for this one cycle
//   LOAD  | FIFO data valid; latch period, compare direction
//   SETUP | new DIR held stable for DIR_SETUP cycles before the rise
//   STEP  | step period running; prefetch at cnt==P-2, reload at cnt==P-1
//
// DIR_SETUP must be >= 1; MIN_PERIOD must be >= PULSE_W+2.
module step_cmd_reader
  import step_cmd_pkg::*;
#(
  parameter int unsigned DATA_W     = CMD_W,
  parameter int unsigned PULSE_W    = 4,
  parameter int unsigned DIR_SETUP  = 2,
  parameter int unsigned MIN_PERIOD = 8
`ifdef STEP_POS_EN
  , parameter int unsigned POS_W    = 24
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic              underrun_clr,
  output logic              fifo_rd_en,
  output logic              step,
  output logic              dir,
  output logic              busy,
  output logic              underrun
`ifdef STEP_POS_EN
  , output logic [POS_W-1:0] position
`endif
);

  localparam logic [7:0] SETUP_LD = 8'(DIR_SETUP - 1);

  state_t              state;
  logic [PERIOD_W-1:0] per_q;
  logic                pf_q;
  logic [7:0]          setup_cnt;

  logic                new_dir;
  logic                same_dir;
  logic [PERIOD_W-1:0] new_per;
  logic                t_start;
  logic                t_run;
  logic                t_pre;
  logic                t_done;

  assign new_dir  = cmd_dir(fifo_data);
  assign same_dir = (new_dir == dir);
  assign new_per  = clamp_period(cmd_period(fifo_data), MIN_PERIOD);
  assign t_run    = (state == STEP);
  assign t_start  = ((state == LOAD)  && same_dir) ||
                    ((state == SETUP) && (setup_cnt == '0)) ||
                    ((state == STEP)  && t_done && pf_q && same_dir);

  step_pulse_timer #(
    .PULSE_W (PULSE_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (t_start),
    .run    (t_run),
    .period (per_q),
    .pulse  (step),
    .pre_pt (t_pre),
    .done   (t_done)
  );

  // Sequencing FSM and FIFO handshake; underrun set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fifo_rd_en <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
      per_q      <= '0;
      pf_q       <= 1'b0;
      setup_cnt  <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      if (underrun_clr) underrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable && !fifo_empty) begin
            state      <= FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          per_q <= new_per;
          if (same_dir) begin
            state <= STEP;
          end else begin
            dir       <= new_dir;
            setup_cnt <= SETUP_LD;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (setup_cnt == '0) state <= STEP;
          else                 setup_cnt <= setup_cnt - 8'd1;
        end
        STEP: begin
          if (t_pre) begin
            if (enable && !fifo_empty) begin
              fifo_rd_en <= 1'b1;
              pf_q       <= 1'b1;
            end else if (enable) begin
              underrun <= 1'b1;
            end
          end
          if (t_done) begin
            pf_q <= 1'b0;
            if (pf_q) begin
              per_q <= new_per;
              if (!same_dir) begin
                dir       <= new_dir;
                setup_cnt <= SETUP_LD;
                state     <= SETUP;
              end
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STEP_POS_EN
  // Track signed position: one count per step rise in the direction being driven.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         position <= '0;
    else if (t_start) position <= dir ? position + POS_W'(1) : position - POS_W'(1);
  end
`endif

endmodule

// File: tb/tb_step_cmd_reader.sv
// Scoreboard bench for step_cmd_reader: a FIFO model feeds command words, a
// reference model pushes the expected step rises (dir + spacing), and a
// negedge monitor pops and compares whenever STEP rises.
module tb_step_cmd_reader;

  localparam int PULSE_W    = 4;
  localparam int DIR_SETUP  = 2;
  localparam int MIN_PERIOD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        underrun_clr;
  logic        fifo_rd_en;
  logic        step;
  logic        dir;
  logic        busy;
  logic        underrun;
`ifdef STEP_POS_EN
  logic [23:0] position;
`endif

  step_cmd_reader dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .underrun_clr (underrun_clr),
    .fifo_rd_en   (fifo_rd_en),
    .step         (step),
    .dir          (dir),
    .busy         (busy),
    .underrun     (underrun)
`ifdef STEP_POS_EN
    , .position   (position)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit dir;
    int gap;
    bit from_rden;
    bit chg;
  } exp_t;

  exp_t        exp_q[$];
  bit [15:0]   fifo_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_rden = 0, last_rise = 0, last_dir_chg = 0, hi_start = 0, busy_fall = 0;
  int          rden_cnt = 0;
  int          exp_pos = 0;
  bit          step_prev = 0, dir_prev = 0, busy_prev = 0, ur_seen = 0;
  bit          cur_dir = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each command gives one rise. The first rise of a run is
  // 2 cycles after the pop (+DIR_SETUP on a direction change); later rises are
  // the previous clamped period apart (+DIR_SETUP on a direction change).
  task automatic model_burst(input bit [15:0] w[$], input bit to_fifo, output int last_p);
    int   prev_p;
    exp_t e;
    prev_p = 0;
    foreach (w[i]) begin
      int p;
      bit d;
      p = int'(w[i] & 16'h7FFF);
      if (p < MIN_PERIOD) p = MIN_PERIOD;
      d = w[i][15];
      e.dir       = d;
      e.chg       = (d != cur_dir);
      e.from_rden = (i == 0);
      e.gap       = ((i == 0) ? 2 : prev_p) + (e.chg ? DIR_SETUP : 0);
      exp_q.push_back(e);
      if (to_fifo) fifo_q.push_back(w[i]);
      prev_p  = p;
      cur_dir = d;
    end
    fifo_empty = (fifo_q.size() == 0);
    last_p = prev_p;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) check({name, "_timeout"}, 1, 0);
    @(negedge clk); #1;
  endtask

  task automatic wait_rise(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check({name, "_timeout"}, 1, 0);
  endtask

  task automatic clear_underrun();
    @(posedge clk); #2;
    enable = 0;
    underrun_clr = 1;
    @(posedge clk); #2;
    underrun_clr = 0;
    check("underrun_clr", underrun, 0);
  endtask

  task automatic run_burst(input bit [15:0] w[$], input bit hold_clr);
    int last_p;
    @(posedge clk); #2;
    enable = 0;
    model_burst(w, 1, last_p);
    rden_cnt = 0;
    ur_seen = 0;
    underrun_clr = hold_clr;
    enable = 1;
    wait_idle("burst");
    check("rd_en_count", rden_cnt, w.size());
    check("busy_tail", busy_fall - last_rise, last_p);
    if (hold_clr) begin
      check("underrun_pulse_seen", ur_seen, 1);
      check("underrun_after_clr", underrun, 0);
    end else begin
      check("underrun_set", underrun, 1);
    end
    clear_underrun();
  endtask

  // FIFO model and monitor/scoreboard, both on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      step_prev = 0;
      dir_prev  = dir;
      busy_prev = 0;
      exp_pos   = 0;
    end else begin
      if (fifo_rd_en) begin
        check("rd_en_while_empty", (fifo_q.size() > 0) ? 1 : 0, 1);
        if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        last_rden  = cyc;
        rden_cnt++;
      end
      if (dir !== dir_prev) last_dir_chg = cyc;
      if (step && !step_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("step_dir", dir, e.dir);
          check("step_gap", cyc - (e.from_rden ? last_rden : last_rise), e.gap);
          if (e.chg) check("dir_setup", cyc - last_dir_chg, DIR_SETUP);
          exp_pos += e.dir ? 1 : -1;
`ifdef STEP_POS_EN
          check("position", int'($signed(position)), exp_pos);
`endif
        end
        last_rise = cyc;
        hi_start  = cyc;
      end
      if (!step && step_prev) check("pulse_width", cyc - hi_start, PULSE_W);
      if (!busy && busy_prev) busy_fall = cyc;
      if (underrun) ur_seen = 1;
      step_prev = step;
      dir_prev  = dir;
      busy_prev = busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [15:0] w[$];
    int        lp;
    rst = 0;
    enable = 0;
    underrun_clr = 0;
    fifo_empty = 1;
    fifo_data = '0;
    #12;
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_rd_en", fifo_rd_en, 0);
`ifdef STEP_POS_EN
    check("rst_position", int'(position), 0);
`endif
    @(posedge clk); #2;
    rst = 1;

    w = {16'h000A};                               run_burst(w, 0);
    w = {16'h8010, 16'h8010, 16'h8010};           run_burst(w, 0);
    w = {16'h800C, 16'h000C};                     run_burst(w, 0);
    w = {16'h0003, 16'h0003};                     run_burst(w, 0);
    w = {16'h0000, 16'h8001, 16'h8007};           run_burst(w, 0);
    w = {16'h000C};                               run_burst(w, 1);

    // Enable dropped mid-step with words still queued: graceful stop.
    @(posedge clk); #2;
    w = {16'h0010};
    model_burst(w, 1, lp);
    fifo_q.push_back(16'h0010);
    fifo_q.push_back(16'h0010);
    fifo_empty = 0;
    rden_cnt = 0;
    enable = 1;
    wait_rise("stop_rise");
    enable = 0;
    wait_idle("stop");
    check("stop_rd_en_count", rden_cnt, 1);
    check("stop_underrun", underrun, 0);
    check("stop_fifo_left", fifo_q.size(), 2);

    // Reset mid-pulse, then the remaining queued word restarts from IDLE.
    w = {16'h0010};
    model_burst(w, 0, lp);
    enable = 1;
    wait_rise("rst_rise");
    check("pre_rst_step", step, 1);
    rst = 0;
    #1;
    check("midrst_step", step, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", fifo_rd_en, 0);
    check("midrst_fifo_kept", fifo_q.size(), 1);
    cur_dir = 0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1;
    model_burst(w, 0, lp);
    wait_idle("after_rst");
    check("after_rst_underrun", underrun, 1);
    clear_underrun();

    // Three forward then one reverse step.
    rst = 0;
    #1;
    cur_dir = 0;
    @(posedge clk); #2;
    rst = 1;
    w = {16'h8008, 16'h8008, 16'h8008, 16'h0008}; run_burst(w, 0);
`ifdef STEP_POS_EN
    check("position_net", int'($signed(position)), 2);
`endif

    for (int b = 0; b < 8; b++) begin
      int n;
      n = $urandom_range(1, 4);
      w = {};
      for (int i = 0; i < n; i++) begin
        bit [15:0] word;
        word[15]   = 1'($urandom_range(0, 1));
        word[14:0] = 15'($urandom_range(0, 40));
        w.push_back(word);
      end
      run_burst(w, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
